// File: rtl/kernel_mac_array.sv
// kernel_mac_array: NUM_LANES parallel 3x3 int8 multiply-accumulate lanes
// sharing one input window stream. A kernel set is latched into shadow
// registers, windows are streamed through a 3-stage pipeline (multiply,
// reduce, accumulate) and a completed group is presented on o_acc.
module kernel_mac_array #(
    parameter int KERNEL_WIDTH = 72,
    parameter int NUM_LANES    = 12,
    parameter int ACC_W        = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              i_kernel_ready,
    input  logic [NUM_LANES*KERNEL_WIDTH-1:0] i_kernels,
    input  logic                              i_win_valid,
    input  logic [KERNEL_WIDTH-1:0]           i_win_data,
    input  logic                              i_win_last,
    input  logic                              i_release,
    output logic                              o_win_ready,
    output logic                              o_acc_valid,
    output logic [NUM_LANES*ACC_W-1:0]        o_acc,
    output logic                              o_busy
);

    localparam int TAPS   = KERNEL_WIDTH / 8;
    localparam int PROD_W = 16;
    localparam int SUM_W  = 20;

    typedef enum logic [1:0] {IDLE, LATCH, RUN, DRAIN} state_t;

    state_t                            state_q, state_d;
    logic [1:0]                        drain_cnt_q, drain_cnt_d;
    logic [NUM_LANES*KERNEL_WIDTH-1:0] kern_q;
    logic                              accept;
    logic                              drain_done;

    logic                              vld_p1, last_p1;
    logic                              vld_p2, last_p2;
    logic signed [PROD_W-1:0]          prod_d  [NUM_LANES][TAPS];
    logic signed [PROD_W-1:0]          prod_p1 [NUM_LANES][TAPS];
    logic signed [SUM_W-1:0]           sum_d   [NUM_LANES];
    logic signed [SUM_W-1:0]           sum_p2  [NUM_LANES];
    logic signed [ACC_W-1:0]           acc_d   [NUM_LANES];
    logic signed [ACC_W-1:0]           acc_q   [NUM_LANES];
    logic                              grp_open_q;
    logic [NUM_LANES*ACC_W-1:0]        acc_out_q;
    logic                              acc_valid_q;

    // Signed int8 x int8; the 16-bit result cannot overflow.
    function automatic logic signed [PROD_W-1:0] mul8(input logic [7:0] a, input logic [7:0] b);
        logic signed [PROD_W-1:0] ea;
        logic signed [PROD_W-1:0] eb;
        ea = {{(PROD_W-8){a[7]}}, a};
        eb = {{(PROD_W-8){b[7]}}, b};
        return ea * eb;
    endfunction

    function automatic logic signed [SUM_W-1:0] sext_sum(input logic signed [PROD_W-1:0] p);
        return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [SUM_W-1:0] s);
        return {{(ACC_W-SUM_W){s[SUM_W-1]}}, s};
    endfunction

    assign accept     = i_win_valid && (state_q == RUN);
    assign drain_done = (state_q == DRAIN) && (drain_cnt_q == 2'd2);

    // Control state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            drain_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state and status outputs; DRAIN holds 3 cycles to flush the pipeline.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        o_win_ready = 1'b0;
        o_busy      = (state_q != IDLE);
        unique case (state_q)
            IDLE:  if (i_kernel_ready) state_d = LATCH;
            LATCH: state_d = RUN;
            RUN: begin
                o_win_ready = 1'b1;
                if (i_release) begin
                    state_d     = DRAIN;
                    drain_cnt_d = 2'd0;
                end
            end
            DRAIN: begin
                if (drain_done) state_d = IDLE;
                else            drain_cnt_d = drain_cnt_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow kernels captured only on the IDLE->LATCH edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            kern_q <= '0;
        end else if (state_q == IDLE && i_kernel_ready) begin
            kern_q <= i_kernels;
        end
    end

    // ---- stage 0 -> 1: per-tap products ----
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            for (int k = 0; k < TAPS; k++) begin
                prod_d[l][k] = mul8(i_win_data[8*k +: 8], kern_q[l*KERNEL_WIDTH + 8*k +: 8]);
            end
        end
    end

    // Stage 1 register: products of the accepted window.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            prod_p1 <= '{default: '0};
        end else begin
            vld_p1  <= accept;
            last_p1 <= accept && i_win_last;
            if (accept) prod_p1 <= prod_d;
        end
    end

    // ---- stage 1 -> 2: reduce 9 products per lane ----
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            sum_d[l] = '0;
            for (int k = 0; k < TAPS; k++) begin
                sum_d[l] = sum_d[l] + sext_sum(prod_p1[l][k]);
            end
        end
    end

    // Stage 2 register: per-lane window dot product.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            sum_p2  <= '{default: '0};
        end else begin
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
            if (vld_p1) sum_p2 <= sum_d;
        end
    end

    // ---- stage 2 -> 3: accumulate; first window of a group loads ----
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            acc_d[l] = (grp_open_q ? acc_q[l] : '0) + sext_acc(sum_p2[l]);
        end
    end

    // Stage 3 register: accumulators, result hold register and group tracking.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q       <= '{default: '0};
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            grp_open_q  <= 1'b0;
        end else begin
            acc_valid_q <= vld_p2 && last_p2;
            if (vld_p2) begin
                acc_q      <= acc_d;
                grp_open_q <= !last_p2;
                if (last_p2) begin
                    for (int l = 0; l < NUM_LANES; l++) begin
                        acc_out_q[l*ACC_W +: ACC_W] <= acc_d[l];
                    end
                end
            end
            // Leaving DRAIN drops any group that never saw its last window.
            if (drain_done) grp_open_q <= 1'b0;
        end
    end

    assign o_acc_valid = acc_valid_q;
    assign o_acc       = acc_out_q;

endmodule

// File: tb/tb_kernel_mac_array.sv
// Testbench for kernel_mac_array: directed and randomized scenarios checked
// against a dot-product/accumulate reference model.
module tb_kernel_mac_array;

    localparam int KW = 72;
    localparam int NL = 12;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              i_kernel_ready = 1'b0;
    logic [NL*KW-1:0]  i_kernels = '0;
    logic              i_win_valid = 1'b0;
    logic [KW-1:0]     i_win_data = '0;
    logic              i_win_last = 1'b0;
    logic              i_release = 1'b0;
    logic              o_win_ready;
    logic              o_acc_valid;
    logic [NL*AW-1:0]  o_acc;
    logic              o_busy;

    always #5 clk = ~clk;

    kernel_mac_array #(.KERNEL_WIDTH(KW), .NUM_LANES(NL), .ACC_W(AW)) dut (
        .clk(clk), .rstn(rstn), .i_kernel_ready(i_kernel_ready), .i_kernels(i_kernels),
        .i_win_valid(i_win_valid), .i_win_data(i_win_data), .i_win_last(i_win_last),
        .i_release(i_release), .o_win_ready(o_win_ready), .o_acc_valid(o_acc_valid),
        .o_acc(o_acc), .o_busy(o_busy)
    );

    typedef struct {
        int              c;
        logic [NL*AW-1:0] v;
    } res_t;

    res_t             caps[$];
    res_t             exps[$];
    res_t             cap_r;
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [NL*KW-1:0] mk;
    logic [AW-1:0]    macc [NL];
    bit               mopen = 0;
    bit               mrun = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_acc_valid === 1'b1) begin
            cap_r.c = cyc;
            cap_r.v = o_acc;
            caps.push_back(cap_r);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [KW-1:0] rnd_win();
        logic [KW-1:0] w;
        for (int t = 0; t < 9; t++) w[8*t +: 8] = 8'($urandom);
        return w;
    endfunction

    function automatic logic [KW-1:0] const_win(input logic [7:0] b);
        logic [KW-1:0] w;
        for (int t = 0; t < 9; t++) w[8*t +: 8] = b;
        return w;
    endfunction

    function automatic logic [NL*KW-1:0] rnd_kern();
        logic [NL*KW-1:0] k;
        for (int i = 0; i < NL*9; i++) k[8*i +: 8] = 8'($urandom);
        return k;
    endfunction

    function automatic logic [NL*KW-1:0] const_kern(input logic [7:0] b);
        logic [NL*KW-1:0] k;
        for (int i = 0; i < NL*9; i++) k[8*i +: 8] = b;
        return k;
    endfunction

    function automatic logic [NL*AW-1:0] splat(input logic [AW-1:0] v);
        logic [NL*AW-1:0] r;
        for (int l = 0; l < NL; l++) r[l*AW +: AW] = v;
        return r;
    endfunction

    // Reference: signed dot product of one lane's latched kernel with a window.
    function automatic logic [AW-1:0] dot(input int lane, input logic [KW-1:0] w);
        int s;
        logic signed [7:0] a;
        logic signed [7:0] b;
        s = 0;
        for (int t = 0; t < 9; t++) begin
            a = mk[lane*KW + 8*t +: 8];
            b = w[8*t +: 8];
            s = s + int'(a) * int'(b);
        end
        return s;
    endfunction

    task automatic load(input logic [NL*KW-1:0] k);
        i_kernels = k;
        i_kernel_ready = 1'b1;
        step();
        i_kernel_ready = 1'b0;
        step();
        mk = k;
        mrun = 1;
        mopen = 0;
    endtask

    // Present one window for one cycle and update the model if it is accepted.
    task automatic present(input logic [KW-1:0] d, input bit last, input bit rel);
        res_t r;
        i_win_valid = 1'b1;
        i_win_data = d;
        i_win_last = last;
        i_release = rel;
        if (mrun) begin
            for (int l = 0; l < NL; l++) macc[l] = (mopen ? macc[l] : '0) + dot(l, d);
            if (last) begin
                r.c = cyc + 3;
                for (int l = 0; l < NL; l++) r.v[l*AW +: AW] = macc[l];
                exps.push_back(r);
                mopen = 0;
            end else begin
                mopen = 1;
            end
            if (rel) begin
                mrun = 0;
                mopen = 0;
            end
        end
        step();
        i_win_valid = 1'b0;
        i_win_last = 1'b0;
        i_release = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step(2);
        n_cmp++; if (o_win_ready !== 1'b0) begin n_bad++; $display("FAIL rst_win_ready got %b want 0", o_win_ready); end
        n_cmp++; if (o_acc_valid !== 1'b0) begin n_bad++; $display("FAIL rst_acc_valid got %b want 0", o_acc_valid); end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", o_busy); end
        n_cmp++; if (o_acc !== '0) begin n_bad++; $display("FAIL rst_acc got %h want 0", o_acc); end
        rstn = 1'b1;
        step();
        // release while idle must be ignored
        i_release = 1'b1;
        step();
        i_release = 1'b0;
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL idle_release_busy got %b want 0", o_busy); end
    endtask

    task automatic test_basic();
        // windows offered in IDLE and LATCH must be dropped
        i_win_valid = 1'b1; i_win_data = const_win(8'h05); i_win_last = 1'b1;
        i_kernels = const_kern(8'h01);
        i_kernel_ready = 1'b1;
        step();
        i_kernel_ready = 1'b0;
        n_cmp++; if (o_busy !== 1'b1 || o_win_ready !== 1'b0) begin n_bad++; $display("FAIL latch_state got busy %b ready %b want 1 0", o_busy, o_win_ready); end
        step();
        i_win_valid = 1'b0; i_win_last = 1'b0;
        mk = const_kern(8'h01); mrun = 1; mopen = 0;
        n_cmp++; if (o_win_ready !== 1'b1) begin n_bad++; $display("FAIL run_ready got %b want 1", o_win_ready); end
        present(const_win(8'h02), 1, 0);
        step(3);
        n_cmp++; if (o_acc !== splat(32'd18)) begin n_bad++; $display("FAIL basic_18 got %h want all 18", o_acc); end
        step(4);
        n_cmp++; if (o_acc !== splat(32'd18)) begin n_bad++; $display("FAIL basic_hold got %h want all 18", o_acc); end
        i_release = 1'b1; step(); i_release = 1'b0; mrun = 0;
        step(4);
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_busy got %b want 0", o_busy); end
        n_cmp++; if (caps.size() !== exps.size()) begin n_bad++; $display("FAIL basic_count got %0d want %0d", caps.size(), exps.size()); end
        foreach (exps[i]) if (i < caps.size()) begin
            n_cmp++;
            if (caps[i].c !== exps[i].c || caps[i].v !== exps[i].v) begin n_bad++; $display("FAIL basic_res[%0d] got cyc %0d %h want cyc %0d %h", i, caps[i].c, caps[i].v, exps[i].c, exps[i].v); end
        end
        caps.delete(); exps.delete();
    endtask

    task automatic test_signed();
        logic [NL*KW-1:0] k;
        k = rnd_kern();
        k[KW-1:0] = const_win(8'h80);
        load(k);
        present(const_win(8'h80), 1, 0);
        step(3);
        n_cmp++; if (o_acc[AW-1:0] !== 32'd147456) begin n_bad++; $display("FAIL signed_pos got %h want %h", o_acc[AW-1:0], 32'd147456); end
        present(const_win(8'h7F), 1, 0);
        step(3);
        n_cmp++; if (o_acc[AW-1:0] !== 32'hFFFDC480) begin n_bad++; $display("FAIL signed_neg got %h want fffdc480", o_acc[AW-1:0]); end
        i_release = 1'b1; step(); i_release = 1'b0; mrun = 0;
        step(4);
        n_cmp++; if (caps.size() !== exps.size()) begin n_bad++; $display("FAIL signed_count got %0d want %0d", caps.size(), exps.size()); end
        foreach (exps[i]) if (i < caps.size()) begin
            n_cmp++;
            if (caps[i].c !== exps[i].c || caps[i].v !== exps[i].v) begin n_bad++; $display("FAIL signed_res[%0d] got cyc %0d %h want cyc %0d %h", i, caps[i].c, caps[i].v, exps[i].c, exps[i].v); end
        end
        caps.delete(); exps.delete();
    endtask

    task automatic test_gaps();
        load(const_kern(8'h01));
        for (int i = 0; i < 4; i++) begin
            step($urandom_range(0, 3));
            present(const_win(8'h02), i == 3, 0);
        end
        step(3);
        n_cmp++; if (o_acc !== splat(32'd72)) begin n_bad++; $display("FAIL gaps_72 got %h want all 72", o_acc); end
        present(const_win(8'h02), 1, 0);
        step(3);
        n_cmp++; if (o_acc !== splat(32'd18)) begin n_bad++; $display("FAIL gaps_18 got %h want all 18", o_acc); end
        i_release = 1'b1; step(); i_release = 1'b0; mrun = 0;
        step(4);
        n_cmp++; if (caps.size() !== 2) begin n_bad++; $display("FAIL gaps_pulses got %0d want 2", caps.size()); end
        foreach (exps[i]) if (i < caps.size()) begin
            n_cmp++;
            if (caps[i].c !== exps[i].c || caps[i].v !== exps[i].v) begin n_bad++; $display("FAIL gaps_res[%0d] got cyc %0d %h want cyc %0d %h", i, caps[i].c, caps[i].v, exps[i].c, exps[i].v); end
        end
        caps.delete(); exps.delete();
    endtask

    task automatic test_back_to_back();
        load(rnd_kern());
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 2));
            n_cmp++; if (o_win_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got %b want 1", i, o_win_ready); end
            present(rnd_win(), $urandom_range(0, 3) == 0, 0);
        end
        // final last window together with release: accepted, result lands in DRAIN
        present(rnd_win(), 1, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (o_busy !== 1'b1 || o_win_ready !== 1'b0) begin n_bad++; $display("FAIL drain_state[%0d] got busy %b ready %b want 1 0", i, o_busy, o_win_ready); end
            step();
        end
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL drain_end_busy got %b want 0", o_busy); end
        step(2);
        n_cmp++; if (caps.size() !== exps.size()) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", caps.size(), exps.size()); end
        foreach (exps[i]) if (i < caps.size()) begin
            n_cmp++;
            if (caps[i].c !== exps[i].c || caps[i].v !== exps[i].v) begin n_bad++; $display("FAIL b2b_res[%0d] got cyc %0d %h want cyc %0d %h", i, caps[i].c, caps[i].v, exps[i].c, exps[i].v); end
        end
        caps.delete(); exps.delete();
    endtask

    task automatic test_kernel_change();
        load(rnd_kern());
        i_kernels = rnd_kern();
        i_kernel_ready = 1'b1;
        for (int i = 0; i < 9; i++) present(rnd_win(), (i % 3) == 2, 0);
        // open group then release: must vanish without a pulse
        present(rnd_win(), 0, 0);
        present(rnd_win(), 0, 0);
        i_kernel_ready = 1'b0;
        i_release = 1'b1; step(); i_release = 1'b0; mrun = 0; mopen = 0;
        step(6);
        n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL kchg_busy got %b want 0", o_busy); end
        n_cmp++; if (caps.size() !== exps.size()) begin n_bad++; $display("FAIL kchg_count got %0d want %0d", caps.size(), exps.size()); end
        foreach (exps[i]) if (i < caps.size()) begin
            n_cmp++;
            if (caps[i].c !== exps[i].c || caps[i].v !== exps[i].v) begin n_bad++; $display("FAIL kchg_res[%0d] got cyc %0d %h want cyc %0d %h", i, caps[i].c, caps[i].v, exps[i].c, exps[i].v); end
        end
        caps.delete(); exps.delete();
        // next group after a discarded one must start from a fresh load
        load(const_kern(8'h01));
        present(const_win(8'h02), 1, 0);
        step(3);
        n_cmp++; if (o_acc !== splat(32'd18)) begin n_bad++; $display("FAIL kchg_fresh got %h want all 18", o_acc); end
        i_release = 1'b1; step(); i_release = 1'b0; mrun = 0;
        step(4);
        caps.delete(); exps.delete();
    endtask

    task automatic test_reset_mid();
        int rcyc;
        load(rnd_kern());
        present(rnd_win(), 0, 0);
        present(rnd_win(), 0, 0);
        present(rnd_win(), 1, 0);
        rstn = 1'b0;
        rcyc = cyc;
        step();
        n_cmp++; if (o_busy !== 1'b0 || o_win_ready !== 1'b0 || o_acc_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_ctrl got busy %b ready %b valid %b want 0 0 0", o_busy, o_win_ready, o_acc_valid); end
        n_cmp++; if (o_acc !== '0) begin n_bad++; $display("FAIL midrst_acc got %h want 0", o_acc); end
        step();
        rstn = 1'b1;
        n_cmp++; if (o_busy !== 1'b0 || o_acc_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_hold got busy %b valid %b want 0 0", o_busy, o_acc_valid); end
        while (exps.size() > 0 && exps[$].c > rcyc) void'(exps.pop_back());
        mrun = 0; mopen = 0;
        step(6);
        n_cmp++; if (caps.size() !== exps.size()) begin n_bad++; $display("FAIL midrst_count got %0d want %0d", caps.size(), exps.size()); end
        n_cmp++; if (o_busy !== 1'b0 || o_acc !== '0) begin n_bad++; $display("FAIL midrst_after got busy %b acc %h want 0 0", o_busy, o_acc); end
        caps.delete(); exps.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_gaps();
        test_back_to_back();
        test_kernel_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kernel_mac_array.md
KERNEL_MAC_ARRAY -- requirements
Module: kernel_mac_array

Interface
REQ-001 SHALL have parameter KERNEL_WIDTH, default 72, width of one 3x3 kernel or window (9 x int8).
REQ-002 SHALL have parameter NUM_LANES, default 12, number of parallel kernel lanes.
REQ-003 SHALL have parameter ACC_W, default 32, accumulator width per lane.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port i_kernel_ready  input  1  kernel set valid; level, driven by the weight controller's o_ready.
REQ-007 SHALL have port i_kernels  input  NUM_LANES*KERNEL_WIDTH  kernel set; lane n at [n*KERNEL_WIDTH +: KERNEL_WIDTH].
REQ-008 SHALL have port i_win_valid  input  1  input window valid.
REQ-009 SHALL have port i_win_data  input  KERNEL_WIDTH  3x3 window; tap k (0..8) at bits [8k+7:8k], signed int8.
REQ-010 SHALL have port i_win_last  input  1  window is the last input channel of the current accumulation group.
REQ-011 SHALL have port i_release  input  1  pulse; current kernel set finished.
REQ-012 SHALL have port o_win_ready  output  1  window accepted when i_win_valid && o_win_ready.
REQ-013 SHALL have port o_acc_valid  output  1  one-cycle pulse; o_acc holds a completed group.
REQ-014 SHALL have port o_acc  output  NUM_LANES*ACC_W  per-lane accumulated result; lane n at [n*ACC_W +: ACC_W].
REQ-015 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, LATCH, RUN, DRAIN.
REQ-017 IDLE -> LATCH when i_kernel_ready=1; i_kernels are copied into internal shadow registers on that edge.
REQ-018 LATCH -> RUN unconditionally after one cycle.
REQ-019 Shadow kernels SHALL hold unchanged through RUN and DRAIN regardless of i_kernel_ready or i_kernels.
REQ-020 o_win_ready SHALL be 1 only in RUN; windows offered in other states are not accepted.
REQ-021 Per lane, stage 1 (cycle after accept) SHALL register 9 signed 8x8 products (16-bit each).
REQ-022 Stage 2 SHALL register the sum of the 9 products, sign-extended to 20 bits.
REQ-023 Stage 3 SHALL add the stage-2 sum into a per-lane ACC_W accumulator (sign-extended, two's-complement wrap on overflow).
REQ-024 The first window of a group SHALL load, not add, the accumulator.
REQ-025 For a window with i_win_last=1 accepted at cycle t, o_acc_valid SHALL be 1 at t+3 with o_acc including that window; the next accepted window starts a new group.
REQ-026 o_acc SHALL hold its value until the next o_acc_valid pulse.
REQ-027 Gaps in i_win_valid SHALL not alter results; pipeline advances with bubbles.
REQ-028 Back-to-back windows (one per cycle) SHALL be accepted with no stall.
REQ-029 RUN -> DRAIN on i_release=1; a window presented in that same cycle is still accepted.
REQ-030 DRAIN SHALL last exactly 3 cycles so in-flight windows complete (including any o_acc_valid), then -> IDLE.
REQ-031 On entering IDLE, an incomplete group (no i_win_last seen) SHALL be discarded without o_acc_valid.
REQ-032 i_release outside RUN SHALL be ignored.

Reset
REQ-033 While rstn=0 at a clock edge: state IDLE; o_win_ready, o_acc_valid, o_busy=0; o_acc, accumulators, pipeline, shadow kernels=0.
REQ-034 Reset mid-RUN SHALL abort all in-flight windows with no o_acc_valid afterwards until new kernels latch.

Verification
REQ-035 Reset: hold rstn=0 two cycles mid-operation -> all outputs 0, state IDLE next cycle.
REQ-036 All kernel bytes 0x01, one window of bytes 0x02 with last=1 -> every lane o_acc=18, o_acc_valid at accept+3.
REQ-037 Signed: lane0 kernel bytes 0x80, window 0x80 -> 147456; window 0x7F -> -146304 (0xFFFDC480).
REQ-038 Four windows (sum 18 each) with gaps, last on 4th -> single pulse o_acc=72; following single last window -> 18.
REQ-039 i_release same cycle as final last window -> that window accepted, result emitted in DRAIN, then o_busy=0 after 3 cycles.
REQ-040 Change i_kernels during RUN -> results use latched set; i_release mid-group -> no o_acc_valid.
